// File: rtl/btn_debounce_encoder.sv
// Four-button synchronizer, debouncer and one-hot encoder feeding the game FSM.
// Emits exactly one registered btn_valid pulse per clean single-button press; chords are locked out.
module btn_debounce_encoder #(
  parameter int DEBOUNCE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk_tick,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic       armed,
  output logic       btn_valid,
  output logic [1:0] btn_val,
  output logic       dropped,
  output logic       chord,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_HELD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  function automatic logic [1:0] f_index(input logic [3:0] onehot);
    logic [1:0] v_idx;
    case (onehot)
      4'b0001: v_idx = 2'd0;
      4'b0010: v_idx = 2'd1;
      4'b0100: v_idx = 2'd2;
      4'b1000: v_idx = 2'd3;
      default: v_idx = 2'd0;
    endcase
    return v_idx;
  endfunction

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_pattern;
  logic [3:0]       w_pattern_nxt;
  logic             r_btn_valid;
  logic             w_btn_valid_nxt;
  logic [1:0]       r_btn_val;
  logic [1:0]       w_btn_val_nxt;
  logic             r_dropped;
  logic             w_dropped_nxt;
  logic             r_chord;
  logic             w_chord_nxt;
  logic             w_none;
  logic             w_onehot;
  logic             w_multi;

  assign w_none   = (r_sync2 == 4'b0000);
  assign w_onehot = !w_none && ((r_sync2 & (r_sync2 - 4'd1)) == 4'b0000);
  assign w_multi  = !w_none && !w_onehot;

  // Two-flop synchronizer per button; only r_sync2 is consumed downstream.
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state and next-output logic of the qualification FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pattern_nxt   = r_pattern;
    w_btn_valid_nxt = 1'b0;
    w_btn_val_nxt   = r_btn_val;
    w_dropped_nxt   = 1'b0;
    w_chord_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_state_nxt   = ST_PRESS;
          w_pattern_nxt = r_sync2;
          w_cnt_nxt     = '0;
        end else if (w_multi) begin
          w_state_nxt = ST_LOCKOUT;
          w_chord_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (w_multi) begin
          w_state_nxt = ST_LOCKOUT;
          w_chord_nxt = 1'b1;
        end else if (w_none) begin
          w_state_nxt = ST_IDLE;
        end else if (r_sync2 == r_pattern) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_state_nxt = ST_HELD;
            if (armed) begin
              w_btn_valid_nxt = 1'b1;
              w_btn_val_nxt   = f_index(r_pattern);
            end else begin
              w_dropped_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end else begin
          // A different single button restarts qualification on that button.
          w_pattern_nxt = r_sync2;
          w_cnt_nxt     = '0;
        end
      end
      ST_HELD: begin
        if (w_none) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (!w_none) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      ST_LOCKOUT: begin
        if (w_none) begin
          w_state_nxt = ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pattern   <= 4'b0000;
      r_btn_valid <= 1'b0;
      r_btn_val   <= 2'd0;
      r_dropped   <= 1'b0;
      r_chord     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pattern   <= w_pattern_nxt;
      r_btn_valid <= w_btn_valid_nxt;
      r_btn_val   <= w_btn_val_nxt;
      r_dropped   <= w_dropped_nxt;
      r_chord     <= w_chord_nxt;
    end
  end

  assign btn_valid = r_btn_valid;
  assign btn_val   = r_btn_val;
  assign dropped   = r_dropped;
  assign chord     = r_chord;
  assign state     = r_state;

endmodule
